// File: rtl/sched_serializador_if.sv
// Lane-side and serial-side signals of the 4:1 byte serializer scheduler.
// The master drives the lanes and enable; the slave (scheduler) drives the serial outputs.
interface sched_serializador_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] data_0p;
    logic [WIDTH-1:0] data_1p;
    logic [WIDTH-1:0] data_2p;
    logic [WIDTH-1:0] data_3p;
    logic             valid_0p;
    logic             valid_1p;
    logic             valid_2p;
    logic             valid_3p;
    logic [WIDTH-1:0] data_000;
    logic             valid_000;
    logic [1:0]       sel;
    logic             frame_strobe;
    logic             IDLE_OUT;

    modport master (
        output enable,
        output data_0p, data_1p, data_2p, data_3p,
        output valid_0p, valid_1p, valid_2p, valid_3p,
        input  data_000, valid_000, sel, frame_strobe, IDLE_OUT
    );

    modport slave (
        input  enable,
        input  data_0p, data_1p, data_2p, data_3p,
        input  valid_0p, valid_1p, valid_2p, valid_3p,
        output data_000, valid_000, sel, frame_strobe, IDLE_OUT
    );
endinterface

// File: rtl/sched_serializador.sv
// Single-clock 4-lane to 1-lane byte serializer scheduler: a 2-bit phase counter replaces
// the divided clocks, one frame is captured every 4 cycles, IDLE/ACTIVE/HOLD owns IDLE_OUT.
module sched_serializador #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [7:0]  IDLE_SYM    = 8'hBC,
    parameter int unsigned IDLE_FRAMES = 2
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    sched_serializador_if.slave   bus
);
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_FRAMES);
    localparam logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(IDLE_SYM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                   phase_q, phase_d;
    logic                         strobe_q, strobe_d;
    logic [LANES-1:0][WIDTH-1:0]  f_data_q, f_data_d;
    logic [LANES-1:0]             f_valid_q, f_valid_d;
    logic [WIDTH-1:0]             out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;

    logic [LANES-1:0][WIDTH-1:0]  lane_data_c;
    logic [LANES-1:0]             lane_valid_c;
    logic                         boundary_c;
    logic                         any_valid_c;
    logic [1:0]                   nxt_lane_c;
    state_e                       emit_state_c;
    logic [WIDTH-1:0]             emit_data_c;
    logic                         emit_valid_c;

    assign lane_data_c  = {bus.data_3p, bus.data_2p, bus.data_1p, bus.data_0p};
    assign lane_valid_c = {bus.valid_3p, bus.valid_2p, bus.valid_1p, bus.valid_0p};
    assign boundary_c   = (phase_q == 2'd3);
    assign any_valid_c  = |lane_valid_c;
    assign nxt_lane_c   = phase_q + 2'd1;

    // State register and all datapath flops.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            strobe_q    <= 1'b0;
            f_data_q    <= '0;
            f_valid_q   <= '0;
            out_data_q  <= IDLE_BYTE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            strobe_q    <= strobe_d;
            f_data_q    <= f_data_d;
            f_valid_q   <= f_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state, evaluated only on the frame-boundary edge; enable=0 overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (boundary_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.enable && any_valid_c) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.enable) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (!any_valid_c) begin
                        if (IDLE_LIM == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.enable) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (any_valid_c) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else if ((cnt_q + CNT_W'(1)) == IDLE_LIM) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Capture and emission: at the boundary lane 0 comes straight from the inputs with the new state.
    always_comb begin
        phase_d   = phase_q + 2'd1;
        strobe_d  = (phase_d == 2'd3);
        f_data_d  = f_data_q;
        f_valid_d = f_valid_q;
        if (boundary_c) begin
            f_data_d     = lane_data_c;
            f_valid_d    = lane_valid_c;
            emit_state_c = state_d;
            emit_data_c  = lane_data_c[0];
            emit_valid_c = lane_valid_c[0];
        end else begin
            emit_state_c = state_q;
            emit_data_c  = f_data_q[nxt_lane_c];
            emit_valid_c = f_valid_q[nxt_lane_c];
        end
        if ((emit_state_c != ST_IDLE) && emit_valid_c) begin
            out_data_d  = emit_data_c;
            out_valid_d = 1'b1;
        end else begin
            out_data_d  = IDLE_BYTE;
            out_valid_d = 1'b0;
        end
    end

    assign bus.data_000     = out_data_q;
    assign bus.valid_000    = out_valid_q;
    assign bus.sel          = phase_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.IDLE_OUT     = (state_q == ST_IDLE);
endmodule

// File: tb/tb_sched_serializador.sv
// Bench for sched_serializador: directed frames from the test plan followed by random
// frames and mid-frame resets, all checked every cycle against a frame-level model.
module tb_sched_serializador;
    localparam int unsigned IDLE_FRAMES = 2;
    localparam logic [7:0]  IDLE_SYM    = 8'hBC;

    logic clk_4f = 1'b0;
    logic reset  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    // Frame-level model: whether the link is in use, run of consecutive empty frames, and
    // the four bytes expected on the serial output during the current frame.
    bit         in_use;
    int         empty_run;
    logic [7:0] exp_d [4];
    logic       exp_v [4];

    sched_serializador_if #(.WIDTH(8)) bus ();

    sched_serializador #(
        .WIDTH       (8),
        .IDLE_SYM    (IDLE_SYM),
        .IDLE_FRAMES (IDLE_FRAMES)
    ) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic set_lanes(input logic en, input logic [31:0] data, input logic [3:0] vm);
        bus.enable   = en;
        bus.data_0p  = data[7:0];
        bus.data_1p  = data[15:8];
        bus.data_2p  = data[23:16];
        bus.data_3p  = data[31:24];
        bus.valid_0p = vm[0];
        bus.valid_1p = vm[1];
        bus.valid_2p = vm[2];
        bus.valid_3p = vm[3];
    endtask

    task automatic model_reset();
        in_use    = 1'b0;
        empty_run = 0;
        for (int k = 0; k < 4; k++) begin
            exp_d[k] = IDLE_SYM;
            exp_v[k] = 1'b0;
        end
    endtask

    task automatic model_capture(input logic en, input logic [31:0] data, input logic [3:0] vm);
        bit any;
        any = (vm != 4'h0);
        if (!in_use) begin
            if (en && any) begin
                in_use    = 1'b1;
                empty_run = 0;
            end
        end else if (!en) begin
            in_use    = 1'b0;
            empty_run = 0;
        end else if (any) begin
            empty_run = 0;
        end else begin
            empty_run++;
            if (empty_run >= int'(IDLE_FRAMES)) begin
                in_use    = 1'b0;
                empty_run = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = in_use && vm[k];
            exp_d[k] = exp_v[k] ? data[k*8 +: 8] : IDLE_SYM;
        end
    endtask

    task automatic check_cycle(input int p);
        chk("sel",          32'(bus.sel),          32'(p));
        chk("frame_strobe", 32'(bus.frame_strobe), 32'(p == 3));
        chk("data_000",     32'(bus.data_000),     32'(exp_d[p]));
        chk("valid_000",    32'(bus.valid_000),    32'(exp_v[p]));
        chk("IDLE_OUT",     32'(bus.IDLE_OUT),     32'(!in_use));
    endtask

    // Holds reset for two cycles, then releases it on a falling edge (phase 0 follows).
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_4f);
            check_cycle(0);
        end
        reset = 1'b1;
    endtask

    // One frame starting mid-cycle in phase 0; lanes are scrambled outside the capture edge.
    // abort_at in 0..3 pulses reset during that phase instead of completing the frame.
    task automatic do_frame(input logic en, input logic [31:0] data, input logic [3:0] vm,
                            input int abort_at);
        for (int p = 0; p < 4; p++) begin
            check_cycle(p);
            if (p == abort_at) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_cycle(0);
                do_reset();
                return;
            end
            if (p == 3) begin
                set_lanes(en, data, vm);
                model_capture(en, data, vm);
            end else begin
                set_lanes(1'($urandom), $urandom, 4'($urandom));
            end
            @(posedge clk_4f);
            @(negedge clk_4f);
        end
    endtask

    initial begin
        set_lanes(1'b0, 32'h0, 4'h0);
        model_reset();
        do_reset();
        // Disabled with valid lanes: link stays idle.
        do_frame(1'b0, 32'hA3A2A1A0, 4'hF, -1);
        do_frame(1'b0, 32'hA3A2A1A0, 4'hF, -1);
        // First enabled frame is emitted in full.
        do_frame(1'b1, 32'h44332211, 4'hF, -1);
        do_frame(1'b1, 32'h88776655, 4'b0101, -1);
        // Two empty frames return to idle.
        do_frame(1'b1, 32'h0, 4'h0, -1);
        do_frame(1'b1, 32'h0, 4'h0, -1);
        // Valid frame between empties keeps the link active.
        do_frame(1'b1, 32'hDEADBEEF, 4'hF, -1);
        do_frame(1'b1, 32'h0, 4'h0, -1);
        do_frame(1'b1, 32'h12345678, 4'b1000, -1);
        do_frame(1'b1, 32'h0, 4'h0, -1);
        do_frame(1'b1, 32'hCAFEF00D, 4'b0110, -1);
        // Enable drop with all lanes valid wins over the data.
        do_frame(1'b0, 32'h99999999, 4'hF, -1);
        do_frame(1'b1, 32'h0A0B0C0D, 4'hF, -1);
        // Reset during phase 2 of an active frame.
        do_frame(1'b1, 32'h01020304, 4'hF, 2);
        do_frame(1'b1, 32'h55AA55AA, 4'hF, -1);
        do_frame(1'b1, 32'h0, 4'h0, -1);
        for (int i = 0; i < 200; i++) begin
            logic        en;
            logic [3:0]  vm;
            int          ab;
            en = ($urandom_range(0, 7) != 0);
            vm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            ab = ($urandom_range(0, 40) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_frame(en, $urandom, vm, ab);
        end
        do_frame(1'b1, 32'h0, 4'h0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
